diag_matrix_builder: RTL and testbench
======================================

Name: diag_matrix_builder

Overview:
- Sequential successor to the combinational diagonal-array generator.
- Builds a ROWS x COLS matrix held in registers. Off-diagonal cells are set to a programmable fill value. One selected diagonal, at signed offset k, is loaded from a valid/ready stream.
- Two load modes: stream mode writes one element per handshake; broadcast mode writes a single scalar to every diagonal cell.
- Sits between vector producers and matrix consumers (systolic arrays, matmul operand staging). The finished matrix is presented on an output valid/ready handshake.

Parameters:
- BIT_WIDTH, 4, element width in bits.
- ROWS, 8, matrix rows.
- COLS, 8, matrix columns.
- OFF_W, $clog2(max(ROWS,COLS))+1, width of the signed offset input. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a build. Sampled only in IDLE.
- offset  input  OFF_W (signed)  diagonal offset k. 0 is the main diagonal; k>0 is above it, k<0 is below it.
- mode  input  1  0 = stream, 1 = broadcast. Captured on start.
- fill  input  BIT_WIDTH  off-diagonal value. Captured on start.
- in_data  input  BIT_WIDTH  diagonal element.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out  output  [BIT_WIDTH-1:0] [ROWS][COLS] (unpacked)  matrix registers, driven continuously.
- out_valid  output  1  out holds a completed matrix.
- out_ready  input  1  consumer takes the matrix.
- busy  output  1  state is not IDLE.
- err  output  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (asynchronous, any state, including mid-load):
  - State goes to IDLE.
  - All out cells, in_ready, out_valid, busy and err go to 0.
  - Internal index and captured values are cleared.
- Legal offset range: -(ROWS-1) <= k <= COLS-1.
- Diagonal geometry, computed at start:
  - r0 = max(0,-k), c0 = max(0,k).
  - Length L = min(ROWS-r0, COLS-c0). L >= 1 for any legal k.
- States: IDLE, LOAD, BCAST, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start with an illegal k: err=1 for the next cycle only; stay in IDLE; out unchanged.
  - On start with a legal k: next cycle every out cell = fill; r0, c0 and L are latched; idx=0; go to LOAD (mode=0) or BCAST (mode=1).
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1 writes in_data to out[r0+idx][c0+idx], then idx increments.
  - The handshake with idx==L-1 moves the state to DONE.
  - Cycles with in_valid=0 change nothing.
- BCAST:
  - in_ready=1.
  - The first handshake writes in_data to all L diagonal cells in one cycle, then goes to DONE.
- DONE:
  - out_valid=1, in_ready=0, out frozen.
  - On out_ready=1, return to IDLE. out_valid is 0 the next cycle; out keeps its values until the next accepted start.
  - Unlimited back-pressure: holding out_ready=0 keeps DONE indefinitely.
- Latency: out_valid rises one cycle after the last input handshake. out_valid is registered, not combinational from in_valid.
- start outside IDLE is ignored and does not pulse err.
- start and out_ready in the same DONE cycle: the start is dropped, because start is only sampled in IDLE.
- busy = (state != IDLE), registered with the state.
- Arithmetic:
  - Indices are unsigned, width $clog2(max(ROWS,COLS)).
  - The offset comparison is signed.
  - No truncation beyond index width is allowed; lint must show no width warnings.

Decomposition:
- Package diag_pkg holds:
  - the state enum (IDLE, LOAD, BCAST, DONE);
  - a function that computes r0/c0/L from k, ROWS and COLS;
  - a function that checks whether k is legal.
- One sub-module, diag_geom, combinationally computes r0, c0, L and the legal flag from offset. It is instantiated once in the top and registered on start.
- Matrix storage and the FSM stay in the top.

Test Plan:
Bench instance is ROWS=4, COLS=6, BIT_WIDTH=4.
- Reset: assert rst mid-LOAD after 2 handshakes -> same edge gives all cells 0, out_valid=0, busy=0, in_ready=0. A new start works normally afterwards.
- Main diagonal, stream: k=0, fill=0, stream 1,2,3,4 -> out[i][i]=i+1 for i=0..3; all other cells 0. out_valid rises the cycle after the 4th handshake.
- Upper diagonal, gapped input: k=+3, fill=0xF, stream 5,6,7 with in_valid low for 2 cycles between items -> L=3, out[0][3]=5, out[1][4]=6, out[2][5]=7; all other cells 0xF.
- Lower diagonal, broadcast with back-pressure: k=-2, mode=1, in_data=0xA, out_ready held low for 10 cycles -> out[2][0]=out[3][1]=0xA, rest fill. out_valid stays 1 and out stable for 10 cycles. out_valid drops one cycle after out_ready=1.
- Illegal offset: k=+6, then k=-4 -> err one-cycle pulse each time, state stays IDLE, in_ready stays 0, out unchanged.
- Ignored start: assert start in LOAD and in DONE -> no err and no state change. The matrix completes exactly as in the main-diagonal test.

Source files
------------

// File: rtl/diag_pkg.sv
// Shared types and diagonal geometry helpers for the diagonal matrix builder.
package diag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BCAST,
        DONE
    } state_t;

    typedef struct packed {
        int r0;
        int c0;
        int len;
    } geom_t;

    function automatic geom_t diag_geom_calc(int k, int rows, int cols);
        geom_t g;
        g.r0  = (k < 0) ? -k : 0;
        g.c0  = (k > 0) ? k : 0;
        g.len = ((rows - g.r0) < (cols - g.c0)) ? (rows - g.r0) : (cols - g.c0);
        return g;
    endfunction

    function automatic logic k_legal(int k, int rows, int cols);
        return (k >= -(rows - 1)) && (k <= (cols - 1));
    endfunction

endpackage

// File: rtl/diag_geom.sv
// Start cell, last index and legality of the diagonal selected by offset.
module diag_geom
    import diag_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int OFF_W = 4,
    parameter int IW    = 3
) (
    input  logic signed [OFF_W-1:0] offset,
    output logic        [IW-1:0]    r0,
    output logic        [IW-1:0]    c0,
    output logic        [IW-1:0]    last,
    output logic                    legal
);

    geom_t g;
    int    k;
    int    last_i;
    logic  unused_bits;

    // last = L-1 so a full-length diagonal still fits the index width
    always_comb begin
        k           = int'(offset);
        g           = diag_geom_calc(k, ROWS, COLS);
        last_i      = g.len - 1;
        legal       = k_legal(k, ROWS, COLS);
        r0          = g.r0[IW-1:0];
        c0          = g.c0[IW-1:0];
        last        = last_i[IW-1:0];
        unused_bits = ^{g.r0[31:IW], g.c0[31:IW], last_i[31:IW], g.len[IW-1:0]};
    end

endmodule

// File: rtl/diag_matrix_builder.sv
// Registered ROWS x COLS matrix: fill everywhere, one diagonal loaded
// from a valid/ready stream (per element or broadcast).
module diag_matrix_builder
    import diag_pkg::*;
#(
    parameter int   BIT_WIDTH = 4,
    parameter int   ROWS      = 8,
    parameter int   COLS      = 8,
    localparam int  MAXD      = (ROWS > COLS) ? ROWS : COLS,
    localparam int  IW        = (MAXD > 1) ? $clog2(MAXD) : 1,
    localparam int  OFF_W     = $clog2(MAXD) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [OFF_W-1:0]     offset,
    input  logic                        mode,
    input  logic        [BIT_WIDTH-1:0] fill,
    input  logic        [BIT_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic        [BIT_WIDTH-1:0] out [ROWS][COLS],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        err
);

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   g_r0;
    logic [IW-1:0]   g_c0;
    logic [IW-1:0]   g_last;
    logic            g_legal;
    logic [IW-1:0]   r0_q;
    logic [IW-1:0]   c0_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   idx;

    diag_geom #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .OFF_W (OFF_W),
        .IW    (IW)
    ) u_geom (
        .offset (offset),
        .r0     (g_r0),
        .c0     (g_c0),
        .last   (g_last),
        .legal  (g_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start && g_legal) state_n = mode ? BCAST : LOAD;
            LOAD:    if (in_valid && (idx == last_q)) state_n = DONE;
            BCAST:   if (in_valid) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD) || (state == BCAST);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    out[r][c] <= '0;
                end
            end
            r0_q   <= '0;
            c0_q   <= '0;
            last_q <= '0;
            idx    <= '0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && g_legal) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                out[r][c] <= fill;
                            end
                        end
                        r0_q   <= g_r0;
                        c0_q   <= g_c0;
                        last_q <= g_last;
                        idx    <= '0;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                if ((IW'(r) == r0_q + idx) && (IW'(c) == c0_q + idx)) begin
                                    out[r][c] <= in_data;
                                end
                            end
                        end
                        idx <= idx + 1'b1;
                    end
                end
                BCAST: begin
                    // every in-bounds cell on the diagonal belongs to it
                    if (in_valid) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                if ((IW'(r) >= r0_q) && (IW'(c) >= c0_q) &&
                                    ((IW'(r) - r0_q) == (IW'(c) - c0_q))) begin
                                    out[r][c] <= in_data;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_diag_matrix_builder.sv
// Directed self-checking bench for diag_matrix_builder (4x6, 4-bit).
module tb_diag_matrix_builder;

    localparam int BW = 4;
    localparam int R  = 4;
    localparam int C  = 6;
    localparam int FW = BW * R * C;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [3:0] offset;
    logic              mode;
    logic [BW-1:0]     fill;
    logic [BW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     out [R][C];
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              err;

    logic [BW-1:0]     exp_m [R][C];
    int                vectors     = 0;
    int                miscompares = 0;

    always #5 clk = ~clk;

    diag_matrix_builder #(
        .BIT_WIDTH (BW),
        .ROWS      (R),
        .COLS      (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .offset    (offset),
        .mode      (mode),
        .fill      (fill),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    function automatic logic [FW-1:0] flat_out();
        logic [FW-1:0] f;
        f = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                f[(r*C+c)*BW +: BW] = out[r][c];
        return f;
    endfunction

    function automatic logic [FW-1:0] flat_exp();
        logic [FW-1:0] f;
        f = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                f[(r*C+c)*BW +: BW] = exp_m[r][c];
        return f;
    endfunction

    task automatic exp_fill(input logic [BW-1:0] v);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                exp_m[r][c] = v;
    endtask

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic signed [3:0] k, input logic m, input logic [BW-1:0] f);
        start  = 1'b1;
        offset = k;
        mode   = m;
        fill   = f;
        step();
        start  = 1'b0;
    endtask

    task automatic push(input logic [BW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; offset = '0; mode = 1'b0; fill = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        exp_fill('0);
        chk("reset_matrix", flat_out(), flat_exp());
        chk("reset_flags", FW'({busy, in_ready, out_valid, err}), FW'(4'b0000));
        rst = 1'b0;
        step();

        // main diagonal, stream, with ignored starts in LOAD and DONE
        do_start(4'sd0, 1'b0, 4'h0);
        chk("main_load_flags", FW'({busy, in_ready, out_valid}), FW'(3'b110));
        push(4'h1);
        start = 1'b1; offset = 4'sd6;
        push(4'h2);
        start = 1'b0;
        chk("main_start_in_load_err", FW'(err), FW'(1'b0));
        push(4'h3);
        chk("main_not_done_yet", FW'(out_valid), FW'(1'b0));
        push(4'h4);
        chk("main_done_flags", FW'({out_valid, in_ready, busy}), FW'(3'b101));
        exp_fill('0);
        exp_m[0][0] = 4'h1; exp_m[1][1] = 4'h2; exp_m[2][2] = 4'h3; exp_m[3][3] = 4'h4;
        chk("main_matrix", flat_out(), flat_exp());
        start = 1'b1; offset = 4'sd6;
        step();
        chk("done_start_ignored", FW'({out_valid, err}), FW'(2'b10));
        offset = 4'sd0; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        chk("done_start_dropped", FW'({out_valid, busy, err}), FW'(3'b000));
        step();
        chk("idle_after_drop", FW'(busy), FW'(1'b0));
        chk("main_matrix_kept", flat_out(), flat_exp());

        // upper diagonal k=+3, gapped stream
        do_start(4'sd3, 1'b0, 4'hF);
        push(4'h5);
        step(); step();
        chk("upper_gap_flags", FW'({in_ready, out_valid}), FW'(2'b10));
        push(4'h6);
        step(); step();
        push(4'h7);
        chk("upper_done", FW'(out_valid), FW'(1'b1));
        exp_fill(4'hF);
        exp_m[0][3] = 4'h5; exp_m[1][4] = 4'h6; exp_m[2][5] = 4'h7;
        chk("upper_matrix", flat_out(), flat_exp());
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("upper_released", FW'(out_valid), FW'(1'b0));

        // lower diagonal k=-2, broadcast, back-pressure
        do_start(-4'sd2, 1'b1, 4'h3);
        exp_fill(4'h3);
        chk("bcast_fill_applied", flat_out(), flat_exp());
        push(4'hA);
        exp_m[2][0] = 4'hA; exp_m[3][1] = 4'hA;
        chk("bcast_done", FW'(out_valid), FW'(1'b1));
        chk("bcast_matrix", flat_out(), flat_exp());
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bcast_hold_valid", FW'(out_valid), FW'(1'b1));
            chk("bcast_hold_matrix", flat_out(), flat_exp());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bcast_released", FW'({out_valid, busy}), FW'(2'b00));

        // illegal offsets
        do_start(4'sd6, 1'b0, 4'h9);
        chk("illegal_p6_err", FW'({err, busy, in_ready}), FW'(3'b100));
        chk("illegal_p6_matrix", flat_out(), flat_exp());
        step();
        chk("illegal_p6_err_drop", FW'(err), FW'(1'b0));
        do_start(-4'sd4, 1'b1, 4'h9);
        chk("illegal_m4_err", FW'({err, busy, in_ready}), FW'(3'b100));
        chk("illegal_m4_matrix", flat_out(), flat_exp());
        step();
        chk("illegal_m4_err_drop", FW'(err), FW'(1'b0));

        // reset mid-LOAD after two handshakes
        do_start(4'sd0, 1'b0, 4'h5);
        push(4'h9);
        push(4'h9);
        rst = 1'b1;
        #1;
        exp_fill('0);
        chk("midload_reset_matrix", flat_out(), flat_exp());
        chk("midload_reset_flags", FW'({busy, in_ready, out_valid, err}), FW'(4'b0000));
        rst = 1'b0;
        step();

        // recovery build k=+1
        do_start(4'sd1, 1'b0, 4'h0);
        push(4'h1);
        push(4'h2);
        push(4'h3);
        chk("recover_not_done", FW'(out_valid), FW'(1'b0));
        push(4'h4);
        exp_m[0][1] = 4'h1; exp_m[1][2] = 4'h2; exp_m[2][3] = 4'h3; exp_m[3][4] = 4'h4;
        chk("recover_done", FW'(out_valid), FW'(1'b1));
        chk("recover_matrix", flat_out(), flat_exp());
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
